// File: rtl/sop_stream_accum.sv
// sop_stream_accum: two-stage multiply/accumulate over in_last-terminated groups with valid/ready result port.
// Build option SOP_SAT_EN clamps the accumulator to all-ones once a group overflows.
module sop_stream_accum #(
  parameter int OP_W   = 9,
  parameter int ACC_W  = 18,
  parameter int TERM_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [OP_W-1:0]   a_in,
  input  logic [OP_W-1:0]   b_in,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [TERM_W-1:0] out_terms,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);
  logic [2*OP_W-1:0] s1_prod_q, s1_prod_d;
  logic              s1_valid_q, s1_last_q, s1_last_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [TERM_W-1:0] cnt_q, cnt_d;
  logic              first_q;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  base;
  logic              accept;
  assign in_ready = !out_valid && !(s1_valid_q && s1_last_q);
  assign accept   = in_valid && in_ready;
  always_comb begin
    s1_prod_d = accept ? {{OP_W{1'b0}}, a_in} * {{OP_W{1'b0}}, b_in} : s1_prod_q;
    s1_last_d = accept ? in_last : s1_last_q;
    base      = first_q ? '0 : acc_q;
    sum       = {1'b0, base} + {{(ACC_W+1-2*OP_W){1'b0}}, s1_prod_q};
    ovf_d     = (first_q ? 1'b0 : ovf_q) | sum[ACC_W];
    cnt_d     = first_q ? {{(TERM_W-1){1'b0}}, 1'b1} : (&cnt_q ? cnt_q : cnt_q + 1'b1);
`ifdef SOP_SAT_EN
    acc_d     = ovf_d ? '1 : sum[ACC_W-1:0];
`else
    acc_d     = sum[ACC_W-1:0];
`endif
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_prod_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      out_sum    <= '0;
      out_terms  <= '0;
      out_ovf    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      s1_prod_q  <= s1_prod_d;
      s1_valid_q <= accept;
      s1_last_q  <= s1_last_d;
      if (s1_valid_q) begin
        acc_q   <= acc_d;
        ovf_q   <= ovf_d;
        cnt_q   <= cnt_d;
        first_q <= s1_last_q;
      end
      // in_ready keeps a new result from landing while one is still pending
      if (s1_valid_q && s1_last_q) begin
        out_sum   <= acc_d;
        out_terms <= cnt_d;
        out_ovf   <= ovf_d;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sop_stream_accum.sv
// tb_sop_stream_accum: directed checks of sop_stream_accum with hand-computed expected values.
module tb_sop_stream_accum;
  logic        clock = 0, reset = 1;
  logic [8:0]  a_in = 0, b_in = 0;
  logic        in_valid = 0, in_last = 0, out_ready = 1;
  logic        in_ready, out_ovf, out_valid;
  logic [17:0] out_sum;
  logic [7:0]  out_terms;
  int errors = 0, checks = 0;

  sop_stream_accum dut (
    .clock(clock), .reset(reset), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_sum(out_sum), .out_terms(out_terms), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [8:0] a, input logic [8:0] b, input logic l);
    int n = 0;
    a_in = a; b_in = b; in_last = l; in_valid = 1;
    while (!in_ready && n < 50) begin step(); n++; end
    chk("send_ready", {31'b0, in_ready}, 1);
    step();
    in_valid = 0;
  endtask

  task automatic chk_out(input string tag, input int s, input int t, input logic o);
    chk({tag, "_valid"}, {31'b0, out_valid}, 1);
    chk({tag, "_sum"}, {14'b0, out_sum}, s);
    chk({tag, "_terms"}, {24'b0, out_terms}, t);
    chk({tag, "_ovf"}, {31'b0, out_ovf}, {31'b0, o});
  endtask

  initial begin
    #1;
    chk("rst_sum", {14'b0, out_sum}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_ready", {31'b0, in_ready}, 1);
    step(); step();
    reset = 0;
    step();

    send(3, 4, 0); send(5, 6, 0); send(7, 8, 0); send(1, 2, 1);
    chk("lat_t1", {31'b0, out_valid}, 0);
    step();
    chk_out("grp4", 100, 4, 0);
    step();
    chk("one_cycle", {31'b0, out_valid}, 0);
    chk("hold_sum", {14'b0, out_sum}, 100);

    send(511, 511, 1);
    step();
    chk_out("single", 261121, 1, 0);
    step();

    send(511, 511, 0); send(511, 511, 1);
    step();
`ifdef SOP_SAT_EN
    chk_out("ovf2", 262143, 2, 1);
`else
    chk_out("ovf2", 260098, 2, 1);
`endif
    step();

    out_ready = 0;
    send(3, 4, 0); send(5, 6, 0); send(7, 8, 0); send(1, 2, 1);
    step();
    a_in = 2; b_in = 2; in_last = 1; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", {31'b0, in_ready}, 0);
      chk("bp_sum", {14'b0, out_sum}, 100);
      chk("bp_valid", {31'b0, out_valid}, 1);
      step();
    end
    out_ready = 1;
    step();
    chk("hs_valid", {31'b0, out_valid}, 0);
    chk("hs_ready", {31'b0, in_ready}, 1);
    step();
    in_valid = 0;
    step();
    chk_out("after_bp", 4, 1, 0);
    step();

    send(10, 10, 0); send(20, 20, 0);
    reset = 1;
    #1;
    chk("mid_rst_sum", {14'b0, out_sum}, 0);
    chk("mid_rst_terms", {24'b0, out_terms}, 0);
    chk("mid_rst_ovf", {31'b0, out_ovf}, 0);
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    step();
    reset = 0;
    step();
    chk("no_partial", {31'b0, out_valid}, 0);
    send(1, 1, 1);
    step();
    chk_out("post_rst", 1, 1, 0);
    step();

    for (int i = 1; i <= 300; i++) send(1, 1, i == 300);
    step();
    chk_out("sat_cnt", 300, 255, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sop_stream_accum.md
Name: sop_stream_accum

Overview:
- Downstream consumer for the sum-of-products datapath.
- Accepts a stream of unsigned 9-bit operand pairs under valid/ready and multiplies each pair in a registered stage.
- Accumulates the products over a group terminated by in_last.
- Presents the group sum, term count and overflow flag on a valid/ready output port.
- Two-stage pipeline (multiply, accumulate); sized so the multiply maps onto a hard multiplier block.

Parameters:
- OP_W, 9: operand width.
- ACC_W, 18: accumulator and result width; must be ≥ 2*OP_W.
- TERM_W, 8: term-counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- a_in  in  OP_W  operand A, unsigned.
- b_in  in  OP_W  operand B, unsigned.
- in_valid  in  1  operand pair valid.
- in_last  in  1  qualifies the pair as the final term of its group.
- in_ready  out  1  block can accept a pair.
- out_sum  out  ACC_W  group sum.
- out_terms  out  TERM_W  number of terms in the group, saturating.
- out_ovf  out  1  accumulation carried past ACC_W in this group.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Asserting reset clears all registers immediately:
  - out_sum=0, out_terms=0, out_ovf=0, out_valid=0.
  - Stage-1 valid and last flags = 0, acc=0, first=1, term count=0.
  - in_ready comes out of reset as 1.
  - Reset mid-group discards the partial group; no output is produced for it.
- Accept: a pair is accepted when in_valid && in_ready.
- in_ready is combinational from registers only: in_ready = !out_valid && !(s1_valid && s1_last).
- Stage 1, on accept:
  - s1_prod <= a_in*b_in, full 2*OP_W width, unsigned.
  - s1_last <= in_last, s1_valid <= 1.
  - Otherwise s1_valid <= 0.
- Stage 2, on s1_valid:
  - sum = (first ? 0 : acc) + zero-extended s1_prod, computed at ACC_W+1 bits.
  - acc <= sum[ACC_W-1:0].
  - ovf_grp <= (first ? 0 : ovf_grp) | sum[ACC_W].
  - term count <= (first ? 1 : cnt+1), saturating at 2^TERM_W-1.
  - first <= s1_last.
- Result, when s1_valid && s1_last:
  - out_sum, out_terms and out_ovf load the updated values; out_valid <= 1.
- Latency: last pair accepted at cycle t gives out_valid=1 at t+2.
- Output handshake:
  - out_valid && out_ready clears out_valid on the next edge.
  - out_sum, out_terms and out_ovf hold until the next result loads.
  - in_ready reasserts in the cycle after the handshake.
- Throughput: one pair per cycle within a group. Minimum gap between groups is 2 cycles plus the output handshake.
- Single-term group (in_last on the first pair) is legal; out_terms=1.
- in_valid=0 cycles inside a group are bubbles: the accumulator holds.
- A result is never overwritten before it is consumed, because in_ready blocks new pairs.
- out_ready with out_valid=0 is ignored.
- No X propagation: a_in, b_in and in_last are sampled only on accept.

Optional Feature:
- Macro SOP_SAT_EN.
- Defined: when a stage-2 add carries out (sum[ACC_W]=1), or ovf_grp is already set within the group, acc is clamped to all-ones. Once set, the clamp holds for the rest of the group. out_ovf is still reported.
- Undefined: acc wraps modulo 2^ACC_W; out_ovf is still reported.
- Port list is identical in both builds.

Test Plan:
- Group (3,4),(5,6),(7,8),(1,2,last), back-to-back, out_ready=1 -> out_sum=100, out_terms=4, out_ovf=0, out_valid at t+2 after the last accept, for exactly one cycle.
- Single pair (511,511,last) -> out_sum=261121, out_terms=1, out_ovf=0.
- Pairs (511,511),(511,511,last):
  - without SOP_SAT_EN -> out_sum=260098, out_ovf=1.
  - with SOP_SAT_EN -> out_sum=262143, out_ovf=1.
- Backpressure: after a group with sum 100, hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, out_sum stays 100. Raise out_ready -> handshake; in_ready=1 the next cycle; the next group (2,2,last) yields 4, with no carry-over from the prior group.
- Reset mid-group: accept (10,10),(20,20), then assert reset 1 cycle -> all outputs 0 immediately; then group (1,1,last) -> out_sum=1, out_terms=1.
- Count saturation (TERM_W=8): 300 pairs (1,1), last on the 300th -> out_sum=300, out_terms=255.
